// File: rtl/rgb2rgbw_conv.sv
// rgb2rgbw_conv: pops GRB words / stream-reset markers from a FIFO, extracts white, emits GRBW words.
// Latency: word popped on edge N is at the buffer head after edge N+2; one word per clock sustained.
// Backpressure: upstream pop is credit-gated on buffer+pipeline occupancy; buffer cannot overflow.
// Build option: define RGB2RGBW_WHITE_EN for white extraction, otherwise W=0 and GRB pass through.
module rgb2rgbw_conv #(
   parameter int OUT_DEPTH = 4,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_rd_fifo_empty,
   input  logic [31:0]      in_rd_fifo_data,
   output logic             out_rd_fifo_en,
   output logic             out_empty,
   output logic [31:0]      out_data,
   output logic             out_str_rst,
   input  logic             in_rd_en,
   output logic [CNT_W-1:0] out_pix_count
);

   localparam int PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
   // Occupancy width must hold buffer count plus both pipeline valid bits.
   localparam int OCC_W = $clog2(OUT_DEPTH + 1) + 1;
   localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(OUT_DEPTH - 1);
   localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(OUT_DEPTH);

   typedef struct packed {
      logic        mrk;
      logic [31:0] dat;
   } ent_t;

   logic             s1_vld_q, s1_vld_d;
   logic [31:0]      s1_dat_q, s1_dat_d;
   logic             s2_vld_q, s2_vld_d;
   ent_t             s2_ent_q, s2_ent_d;
   ent_t             mem_q [OUT_DEPTH];
   ent_t             mem_d [OUT_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [OCC_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] pix_q, pix_d;

   logic [OCC_W-1:0] occ;
   logic             pop_up;
   logic             buf_wr;
   logic             buf_rd;
   logic [7:0]       g_v, r_v, b_v, w_v;

   // Credit check: everything already popped but not yet consumed downstream must fit in the buffer.
   always_comb begin
      occ    = cnt_q + OCC_W'(s1_vld_q) + OCC_W'(s2_vld_q);
      pop_up = rst & ~in_rd_fifo_empty & (occ < DEPTH_OCC);
   end

   // S1 capture and S2 conversion; markers become zero-data entries flagged as stream resets.
   always_comb begin
      g_v = s1_dat_q[23:16];
      r_v = s1_dat_q[15:8];
      b_v = s1_dat_q[7:0];
`ifdef RGB2RGBW_WHITE_EN
      w_v = (g_v < r_v) ? g_v : r_v;
      w_v = (w_v < b_v) ? w_v : b_v;
`else
      w_v = 8'h00;
`endif
      s1_vld_d = pop_up;
      s1_dat_d = pop_up ? in_rd_fifo_data : s1_dat_q;
      s2_vld_d = s1_vld_q;
      s2_ent_d = s2_ent_q;
      if (s1_vld_q) begin
         if (|s1_dat_q[31:24]) begin
            s2_ent_d.mrk = 1'b1;
            s2_ent_d.dat = 32'h0;
         end else begin
            s2_ent_d.mrk = 1'b0;
            s2_ent_d.dat = {g_v - w_v, r_v - w_v, b_v - w_v, w_v};
         end
      end
   end

   // Circular output buffer and pixel counter; counter moves on the edge an entry is written.
   always_comb begin
      buf_wr   = s2_vld_q;
      buf_rd   = in_rd_en & (cnt_q != '0);
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      pix_d    = pix_q;
      if (buf_wr) begin
         mem_d[wr_ptr_q] = s2_ent_q;
         wr_ptr_d        = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
         if (s2_ent_q.mrk) begin
            pix_d = '0;
         end else if (pix_q != '1) begin
            pix_d = pix_q + 1'b1;
         end
      end
      if (buf_rd) begin
         rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
      end
      case ({buf_wr, buf_rd})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   // Head presentation; outputs are forced to zero when the buffer is empty.
   always_comb begin
      out_rd_fifo_en = pop_up;
      out_empty      = (cnt_q == '0);
      out_data       = out_empty ? 32'h0 : mem_q[rd_ptr_q].dat;
      out_str_rst    = out_empty ? 1'b0  : mem_q[rd_ptr_q].mrk;
      out_pix_count  = pix_q;
   end

   // State registers; reset discards pipeline and buffer contents immediately.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_vld_q <= 1'b0;
         s1_dat_q <= '0;
         s2_vld_q <= 1'b0;
         s2_ent_q <= '0;
         for (int i = 0; i < OUT_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         pix_q    <= '0;
      end else begin
         s1_vld_q <= s1_vld_d;
         s1_dat_q <= s1_dat_d;
         s2_vld_q <= s2_vld_d;
         s2_ent_q <= s2_ent_d;
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         pix_q    <= pix_d;
      end
   end

endmodule

// File: tb/tb_rgb2rgbw_conv.sv
// tb_rgb2rgbw_conv: directed stimulus with a queue-based reference model checked every cycle.
// Upstream FIFO is modelled as a first-word-fall-through queue inside the bench.
// Downstream pops are driven by the stimulus through in_rd_en.
module tb_rgb2rgbw_conv;

   localparam int DEPTH = 4;

`ifdef RGB2RGBW_WHITE_EN
   localparam logic [31:0] EXP_CONV = 32'h00204020;
   localparam logic [31:0] EXP_GREY = 32'h000000FF;
`else
   localparam logic [31:0] EXP_CONV = 32'h20406000;
   localparam logic [31:0] EXP_GREY = 32'hFFFFFF00;
`endif

   typedef struct {
      logic [31:0] dat;
      logic        mrk;
      int          ready;
   } item_t;

   logic        clk;
   logic        rst;
   logic        in_rd_fifo_empty;
   logic [31:0] in_rd_fifo_data;
   logic        out_rd_fifo_en;
   logic        out_empty;
   logic [31:0] out_data;
   logic        out_str_rst;
   logic        in_rd_en;
   logic [15:0] out_pix_count;

   logic [31:0] up_q[$];
   item_t       exp_q[$];
   logic [15:0] mdl_cnt;
   int          edge_cnt;
   int          pop_total;
   int          rd_total;
   int          n_chk;
   int          n_pass;

   rgb2rgbw_conv dut (
      .clk              (clk),
      .rst              (rst),
      .in_rd_fifo_empty (in_rd_fifo_empty),
      .in_rd_fifo_data  (in_rd_fifo_data),
      .out_rd_fifo_en   (out_rd_fifo_en),
      .out_empty        (out_empty),
      .out_data         (out_data),
      .out_str_rst      (out_str_rst),
      .in_rd_en         (in_rd_en),
      .out_pix_count    (out_pix_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference conversion straight from the colour rules: {marker, data}.
   function automatic logic [32:0] conv(input logic [31:0] wd);
      logic [7:0] g, r, b, m;
      g = wd[23:16];
      r = wd[15:8];
      b = wd[7:0];
      if (wd[31:24] != 8'h00) return {1'b1, 32'h0};
`ifdef RGB2RGBW_WHITE_EN
      m = g;
      if (r < m) m = r;
      if (b < m) m = b;
      return {1'b0, g - m, r - m, b - m, m};
`else
      return {1'b0, g, r, b, 8'h00};
`endif
   endfunction

   function automatic logic head_ready();
      return (exp_q.size() > 0) && (exp_q[0].ready <= edge_cnt);
   endfunction

   task automatic drive_up();
      in_rd_fifo_empty = (up_q.size() == 0);
      in_rd_fifo_data  = (up_q.size() != 0) ? up_q[0] : 32'h0;
   endtask

   task automatic push(input logic [31:0] wd);
      up_q.push_back(wd);
      drive_up();
   endtask

   // Per-cycle comparison of every observable output against the model.
   task automatic compare();
      logic exp_empty;
      exp_empty = !head_ready();
      chk("empty", out_empty, exp_empty);
      if (!exp_empty) begin
         chk("data", out_data, exp_q[0].dat);
         chk("str_rst", out_str_rst, exp_q[0].mrk);
      end
      chk("pix_count", out_pix_count, mdl_cnt);
      chk("pop_rule", out_rd_fifo_en, (up_q.size() != 0) && (exp_q.size() < DEPTH));
   endtask

   // One clock: sample handshakes before the edge, advance the model, check after the falling edge.
   task automatic tick();
      logic  pop, rd;
      logic [32:0] cv;
      item_t it;
      #1;
      pop = out_rd_fifo_en;
      rd  = in_rd_en && head_ready();
      @(posedge clk);
      edge_cnt++;
      if (rd) begin
         void'(exp_q.pop_front());
         rd_total++;
      end
      if (pop && up_q.size() != 0) begin
         cv       = conv(up_q[0]);
         it.dat   = cv[31:0];
         it.mrk   = cv[32];
         it.ready = edge_cnt + 2;
         exp_q.push_back(it);
         void'(up_q.pop_front());
         pop_total++;
      end
      foreach (exp_q[i]) begin
         if (exp_q[i].ready == edge_cnt) begin
            if (exp_q[i].mrk) mdl_cnt = 16'h0;
            else if (mdl_cnt != 16'hFFFF) mdl_cnt = mdl_cnt + 16'h1;
         end
      end
      @(negedge clk);
      drive_up();
      #1;
      compare();
   endtask

   task automatic drain(input string name);
      in_rd_en = 1'b1;
      for (int i = 0; i < 60 && (exp_q.size() + up_q.size()) != 0; i++) tick();
      chk(name, exp_q.size() + up_q.size(), 0);
      in_rd_en = 1'b0;
   endtask

   task automatic chk_reset_vals();
      chk("rst_fifo_en", out_rd_fifo_en, 0);
      chk("rst_empty", out_empty, 1);
      chk("rst_data", out_data, 0);
      chk("rst_str_rst", out_str_rst, 0);
      chk("rst_pix_count", out_pix_count, 0);
   endtask

   initial begin
      int p0, r0;
      n_chk = 0; n_pass = 0; edge_cnt = 0; pop_total = 0; rd_total = 0;
      mdl_cnt  = 16'h0;
      rst      = 1'b0;
      in_rd_en = 1'b0;
      drive_up();

      // Model self-pins against hand-computed values.
      chk("model_conv", conv(32'h00204060), {1'b0, EXP_CONV});
      chk("model_grey", conv(32'h00FFFFFF), {1'b0, EXP_GREY});
      chk("model_marker", conv(32'h01000000), {1'b1, 32'h0});

      #2;
      chk_reset_vals();
      @(negedge clk);
      rst = 1'b1;

      // Marker and counter: 3 pixels, marker, 1 pixel.
      push(32'h00102030); push(32'h00FF0080); push(32'h00050505);
      repeat (5) tick();
      chk("cnt_after_3", out_pix_count, 3);
      push(32'h01000000);
      repeat (3) tick();
      chk("cnt_after_mrk", out_pix_count, 0);
      push(32'h00010203);
      drain("drain_marker");
      chk("cnt_after_1", out_pix_count, 1);

      // Conversion of a single pixel.
      push(32'h00204060);
      repeat (3) tick();
      chk("conv_data", out_data, EXP_CONV);
      chk("conv_str_rst", out_str_rst, 0);
      drain("drain_conv");

      // Grey and black.
      push(32'h00FFFFFF); push(32'h00000000);
      repeat (4) tick();
      chk("grey_data", out_data, EXP_GREY);
      in_rd_en = 1'b1;
      tick();
      in_rd_en = 1'b0;
      chk("black_data", out_data, 32'h0);
      drain("drain_grey");

      // Latency, then popping an empty buffer.
      p0 = pop_total;
      push(32'h00102030);
      tick();
      chk("lat_popped", pop_total - p0, 1);
      tick();
      chk("lat_n1_empty", out_empty, 1);
      tick();
      chk("lat_n2_valid", out_empty, 0);
      in_rd_en = 1'b1;
      repeat (4) tick();
      chk("emptypop_empty", out_empty, 1);
      chk("emptypop_cnt", out_pix_count, 5);
      push(32'h00808040);
      drain("drain_lat");

      // Backpressure with 10 upstream words.
      p0 = pop_total;
      for (int i = 1; i <= 10; i++) push({8'h00, 8'(i * 17), 8'(i * 5), 8'(i * 11)});
      repeat (10) tick();
      chk("bp_pops", pop_total - p0, DEPTH);
      chk("bp_fifo_en", out_rd_fifo_en, 0);
      r0 = rd_total;
      in_rd_en = 1'b1;
      repeat (10) tick();
      chk("bp_drained", rd_total - r0, 10);
      chk("bp_empty", out_empty, 1);
      in_rd_en = 1'b0;
      drain("drain_bp");

      // Reset mid-stream: 2 buffered, 1 in S2, one word waiting upstream.
      push(32'h00AA5511); push(32'h00112233); push(32'h00C0C0C0);
      repeat (4) tick();
      push(32'h00204060);
      rst = 1'b0;
      #1;
      chk_reset_vals();
      exp_q.delete();
      mdl_cnt = 16'h0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      drive_up();
      p0 = pop_total;
      tick();
      chk("rr_popped", pop_total - p0, 1);
      tick();
      chk("rr_n1_empty", out_empty, 1);
      tick();
      chk("rr_n2_valid", out_empty, 0);
      chk("rr_data", out_data, EXP_CONV);
      drain("drain_rr");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
